// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue
//  Purpose  : Single-entry ALU issue register. Resolves operand forwarding
//             from EX/MEM and MEM/WB, detects load-use hazards and inserts
//             bubbles, and presents a fully registered payload to the ALU.
//  Revision : 1.0  initial release
// ============================================================================
module alu_issue (
  input  logic        clk_i,
  input  logic        rst_i,
  // decode handshake
  input  logic        dec_valid_i,
  output logic        dec_ready_o,
  // decode payload
  input  logic [3:0]  dec_op_type_i,
  input  logic [6:0]  dec_fu_op_i,
  input  logic [4:0]  dec_rs1_i,
  input  logic [4:0]  dec_rs2_i,
  input  logic        dec_use_rs1_i,
  input  logic        dec_use_rs2_i,
  input  logic [63:0] dec_rs1_data_i,
  input  logic [63:0] dec_rs2_data_i,
  input  logic [63:0] dec_imm_i,
  input  logic        dec_use_imm_i,
  input  logic [4:0]  dec_rd_i,
  // EX/MEM forward
  input  logic        exmem_wen_i,
  input  logic        exmem_is_load_i,
  input  logic [4:0]  exmem_rd_i,
  input  logic [63:0] exmem_data_i,
  // MEM/WB forward
  input  logic        memwb_wen_i,
  input  logic [4:0]  memwb_rd_i,
  input  logic [63:0] memwb_data_i,
  // control
  input  logic        ex_stall_i,
  input  logic        flush_i,
  // ALU side
  output logic        ex_valid_o,
  output logic [3:0]  op_type_o,
  output logic [6:0]  fu_op_o,
  output logic [63:0] operand_a_o,
  output logic [63:0] operand_b_o,
  output logic [63:0] imm_o,
  output logic [4:0]  rd_o,
  output logic [31:0] stall_cnt_o
);

  localparam logic [4:0]  C_X0      = 5'd0;
  localparam logic [31:0] C_CNT_MAX = 32'hFFFF_FFFF;

  logic        w_hazard;
  logic        w_accept;
  logic [63:0] w_fwd_rs1;
  logic [63:0] w_fwd_rs2;

  logic        ex_valid_q,  ex_valid_d;
  logic [3:0]  op_type_q,   op_type_d;
  logic [6:0]  fu_op_q,     fu_op_d;
  logic [63:0] operand_a_q, operand_a_d;
  logic [63:0] operand_b_q, operand_b_d;
  logic [63:0] imm_q,       imm_d;
  logic [4:0]  rd_q,        rd_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Load-use hazard: a load in EX/MEM whose result a decoded source needs.
  always_comb begin
    w_hazard = dec_valid_i & exmem_wen_i & exmem_is_load_i & (exmem_rd_i != C_X0) &
               ((dec_use_rs1_i & (dec_rs1_i == exmem_rd_i)) |
                (dec_use_rs2_i & (dec_rs2_i == exmem_rd_i)));
    // Ready is held low during reset so nothing is consumed from decode.
    dec_ready_o = ~rst_i & ~ex_stall_i & ~w_hazard & ~flush_i;
    w_accept    = dec_valid_i & dec_ready_o;
  end

  // Operand forwarding: youngest producer wins; x0 always reads the file value.
  // An EX/MEM load is skipped because its data is not available yet.
  always_comb begin
    w_fwd_rs1 = dec_rs1_data_i;
    if (dec_rs1_i != C_X0) begin
      if (exmem_wen_i && !exmem_is_load_i && (exmem_rd_i == dec_rs1_i))
        w_fwd_rs1 = exmem_data_i;
      else if (memwb_wen_i && (memwb_rd_i == dec_rs1_i))
        w_fwd_rs1 = memwb_data_i;
    end
    w_fwd_rs2 = dec_rs2_data_i;
    if (dec_rs2_i != C_X0) begin
      if (exmem_wen_i && !exmem_is_load_i && (exmem_rd_i == dec_rs2_i))
        w_fwd_rs2 = exmem_data_i;
      else if (memwb_wen_i && (memwb_rd_i == dec_rs2_i))
        w_fwd_rs2 = memwb_data_i;
    end
  end

  // Issue slot next state: flush kills, stall holds, otherwise load or bubble.
  // On a bubble the payload fields keep their previous (defined) contents.
  always_comb begin
    ex_valid_d  = ex_valid_q;
    op_type_d   = op_type_q;
    fu_op_d     = fu_op_q;
    operand_a_d = operand_a_q;
    operand_b_d = operand_b_q;
    imm_d       = imm_q;
    rd_d        = rd_q;
    stall_cnt_d = stall_cnt_q;
    if (flush_i) begin
      ex_valid_d = 1'b0;
    end else if (!ex_stall_i) begin
      if (w_accept) begin
        ex_valid_d  = 1'b1;
        op_type_d   = dec_op_type_i;
        fu_op_d     = dec_fu_op_i;
        operand_a_d = w_fwd_rs1;
        operand_b_d = dec_use_imm_i ? dec_imm_i : w_fwd_rs2;
        imm_d       = dec_imm_i;
        rd_d        = dec_rd_i;
      end else begin
        ex_valid_d = 1'b0;
        if (w_hazard && (stall_cnt_q != C_CNT_MAX))
          stall_cnt_d = stall_cnt_q + 32'd1;
      end
    end
  end

  // State register with synchronous reset overriding every other control.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_q  <= 1'b0;
      op_type_q   <= '0;
      fu_op_q     <= '0;
      operand_a_q <= '0;
      operand_b_q <= '0;
      imm_q       <= '0;
      rd_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      op_type_q   <= op_type_d;
      fu_op_q     <= fu_op_d;
      operand_a_q <= operand_a_d;
      operand_b_q <= operand_b_d;
      imm_q       <= imm_d;
      rd_q        <= rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid_o  = ex_valid_q;
  assign op_type_o   = op_type_q;
  assign fu_op_o     = fu_op_q;
  assign operand_a_o = operand_a_q;
  assign operand_b_o = operand_b_q;
  assign imm_o       = imm_q;
  assign rd_o        = rd_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue
//  Purpose  : Self-checking bench for alu_issue: directed scenarios followed
//             by randomized traffic compared against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid, dec_ready;
  logic [3:0]  dec_op_type;
  logic [6:0]  dec_fu_op;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_use_rs1, dec_use_rs2, dec_use_imm;
  logic [63:0] dec_rs1_data, dec_rs2_data, dec_imm;
  logic        exmem_wen, exmem_is_load;
  logic [4:0]  exmem_rd;
  logic [63:0] exmem_data;
  logic        memwb_wen;
  logic [4:0]  memwb_rd;
  logic [63:0] memwb_data;
  logic        ex_stall, flush;
  logic        ex_valid;
  logic [3:0]  op_type;
  logic [6:0]  fu_op;
  logic [63:0] operand_a, operand_b, imm;
  logic [4:0]  rd;
  logic [31:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected ALU-side state
  logic        m_valid;
  logic [3:0]  m_op;
  logic [6:0]  m_fu;
  logic [63:0] m_a, m_b, m_imm;
  logic [4:0]  m_rd;
  logic [31:0] m_cnt;

  alu_issue dut (
    .clk_i(clk), .rst_i(rst),
    .dec_valid_i(dec_valid), .dec_ready_o(dec_ready),
    .dec_op_type_i(dec_op_type), .dec_fu_op_i(dec_fu_op),
    .dec_rs1_i(dec_rs1), .dec_rs2_i(dec_rs2),
    .dec_use_rs1_i(dec_use_rs1), .dec_use_rs2_i(dec_use_rs2),
    .dec_rs1_data_i(dec_rs1_data), .dec_rs2_data_i(dec_rs2_data),
    .dec_imm_i(dec_imm), .dec_use_imm_i(dec_use_imm), .dec_rd_i(dec_rd),
    .exmem_wen_i(exmem_wen), .exmem_is_load_i(exmem_is_load),
    .exmem_rd_i(exmem_rd), .exmem_data_i(exmem_data),
    .memwb_wen_i(memwb_wen), .memwb_rd_i(memwb_rd), .memwb_data_i(memwb_data),
    .ex_stall_i(ex_stall), .flush_i(flush),
    .ex_valid_o(ex_valid), .op_type_o(op_type), .fu_op_o(fu_op),
    .operand_a_o(operand_a), .operand_b_o(operand_b), .imm_o(imm),
    .rd_o(rd), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value a source register should deliver given the bypass network contents.
  function automatic logic [63:0] src_value(input logic [4:0] r, input logic [63:0] file_val);
    if (r == 5'd0) return file_val;
    if (exmem_wen && !exmem_is_load && exmem_rd == r) return exmem_data;
    if (memwb_wen && memwb_rd == r) return memwb_data;
    return file_val;
  endfunction

  function automatic logic needs_loaded_reg();
    if (!(dec_valid && exmem_wen && exmem_is_load && exmem_rd != 5'd0)) return 1'b0;
    return (dec_use_rs1 && dec_rs1 == exmem_rd) || (dec_use_rs2 && dec_rs2 == exmem_rd);
  endfunction

  task automatic clear_inputs();
    rst = 0; dec_valid = 0; dec_op_type = 0; dec_fu_op = 0;
    dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; dec_use_rs1 = 0; dec_use_rs2 = 0;
    dec_use_imm = 0; dec_rs1_data = 0; dec_rs2_data = 0; dec_imm = 0;
    exmem_wen = 0; exmem_is_load = 0; exmem_rd = 0; exmem_data = 0;
    memwb_wen = 0; memwb_rd = 0; memwb_data = 0; ex_stall = 0; flush = 0;
  endtask

  // One clock: check ready, advance the model, check registered outputs.
  task automatic step();
    logic load_use, exp_ready;
    #1;
    load_use  = needs_loaded_reg();
    exp_ready = !rst && !ex_stall && !flush && !load_use;
    chk("dec_ready", {63'd0, dec_ready}, {63'd0, exp_ready});
    if (rst) begin
      m_valid = 0; m_op = 0; m_fu = 0; m_a = 0; m_b = 0; m_imm = 0; m_rd = 0; m_cnt = 0;
    end else if (flush) begin
      m_valid = 0;
    end else if (!ex_stall) begin
      if (load_use) begin
        m_valid = 0;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end else if (dec_valid) begin
        m_valid = 1; m_op = dec_op_type; m_fu = dec_fu_op; m_rd = dec_rd;
        m_a = src_value(dec_rs1, dec_rs1_data);
        m_b = dec_use_imm ? dec_imm : src_value(dec_rs2, dec_rs2_data);
        m_imm = dec_imm;
      end else begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("ex_valid", {63'd0, ex_valid}, {63'd0, m_valid});
    chk("stall_cnt", {32'd0, stall_cnt}, {32'd0, m_cnt});
    if (m_valid) begin
      chk("op_type", {60'd0, op_type}, {60'd0, m_op});
      chk("fu_op", {57'd0, fu_op}, {57'd0, m_fu});
      chk("operand_a", operand_a, m_a);
      chk("operand_b", operand_b, m_b);
      chk("imm", imm, m_imm);
      chk("rd", {59'd0, rd}, {59'd0, m_rd});
    end else begin
      chk("payload_known", {63'd0, $isunknown({op_type, fu_op, operand_a, operand_b, imm, rd})}, 64'd0);
    end
  endtask

  initial begin
    logic [63:0] frz_a, frz_b;
    m_valid = 0; m_op = 0; m_fu = 0; m_a = 0; m_b = 0; m_imm = 0; m_rd = 0; m_cnt = 0;
    clear_inputs();
    @(posedge clk); #1;

    // Reset, with flush/stall also asserted to show reset dominates
    rst = 1; flush = 1; ex_stall = 1; dec_valid = 1;
    step(); step();
    chk("rst_operand_a", operand_a, 64'd0);
    chk("rst_operand_b", operand_b, 64'd0);
    chk("rst_imm", imm, 64'd0);
    chk("rst_misc", {33'd0, op_type, fu_op, rd, ex_valid, stall_cnt}, 64'd0);
    clear_inputs();

    // Plain issue
    dec_valid = 1; dec_rs1 = 3; dec_rs2 = 4; dec_use_rs1 = 1; dec_use_rs2 = 1;
    dec_rs1_data = 64'h10; dec_rs2_data = 64'h20; dec_rd = 9; dec_op_type = 4'h2; dec_fu_op = 7'h11;
    step();
    chk("plain_valid", {63'd0, ex_valid}, 64'd1);
    chk("plain_a", operand_a, 64'h10);
    chk("plain_b", operand_b, 64'h20);

    // Dual match: EX/MEM has priority over MEM/WB
    dec_rs1 = 5; exmem_wen = 1; exmem_rd = 5; exmem_data = 64'hAA;
    memwb_wen = 1; memwb_rd = 5; memwb_data = 64'hBB;
    step();
    chk("dual_a", operand_a, 64'hAA);
    clear_inputs();

    // Load-use: one bubble, then MEM/WB supplies the load result
    dec_valid = 1; dec_rs2 = 7; dec_use_rs2 = 1; dec_rs2_data = 64'h1;
    exmem_wen = 1; exmem_is_load = 1; exmem_rd = 7; exmem_data = 64'hDEAD;
    step();
    chk("lu_bubble", {63'd0, ex_valid}, 64'd0);
    chk("lu_cnt", {32'd0, stall_cnt}, 64'd1);
    exmem_wen = 0; exmem_is_load = 0; exmem_rd = 0;
    memwb_wen = 1; memwb_rd = 7; memwb_data = 64'h55;
    step();
    chk("lu_b", operand_b, 64'h55);
    chk("lu_valid", {63'd0, ex_valid}, 64'd1);
    clear_inputs();

    // x0 is never forwarded
    dec_valid = 1; dec_rs1 = 0; dec_use_rs1 = 1; dec_rs1_data = 0;
    exmem_wen = 1; exmem_rd = 0; exmem_data = 64'hFF;
    memwb_wen = 1; memwb_rd = 0; memwb_data = 64'hEE;
    step();
    chk("x0_a", operand_a, 64'd0);
    clear_inputs();

    // Stall freezes outputs, flush under stall clears valid
    dec_valid = 1; dec_rs1 = 2; dec_rs1_data = 64'h1234; dec_rs2 = 6; dec_rs2_data = 64'h5678;
    step();
    frz_a = operand_a; frz_b = operand_b;
    ex_stall = 1; dec_rs1_data = 64'h9999; dec_rs2_data = 64'h8888;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_frozen_a", operand_a, 64'h1234);
      chk("stall_frozen_b", operand_b, 64'h5678);
      chk("stall_frozen_v", {63'd0, ex_valid}, 64'd1);
    end
    flush = 1;
    step();
    chk("flush_valid", {63'd0, ex_valid}, 64'd0);
    clear_inputs();

    // Immediate overrides a forwarded rs2
    dec_valid = 1; dec_use_imm = 1; dec_imm = 64'hFFFF_FFFF_FFFF_FFFC;
    dec_rs2 = 8; dec_use_rs2 = 1; memwb_wen = 1; memwb_rd = 8; memwb_data = 64'h77;
    step();
    chk("imm_b", operand_b, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("imm_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
    clear_inputs();

    // Reset mid-hazard: nothing counted, held instruction discarded
    dec_valid = 1; dec_rs1 = 4; dec_use_rs1 = 1; exmem_wen = 1; exmem_is_load = 1; exmem_rd = 4;
    rst = 1;
    step();
    chk("rst_hazard_cnt", {32'd0, stall_cnt}, 64'd0);
    clear_inputs();
    step();
    chk("rst_hazard_valid", {63'd0, ex_valid}, 64'd0);

    // Randomized traffic, small register range to provoke matches
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(0, 99) < 2);
      ex_stall      = ($urandom_range(0, 99) < 20);
      flush         = ($urandom_range(0, 99) < 8);
      dec_valid     = ($urandom_range(0, 99) < 80);
      dec_op_type   = 4'($urandom);
      dec_fu_op     = 7'($urandom);
      dec_rs1       = 5'($urandom_range(0, 3));
      dec_rs2       = 5'($urandom_range(0, 3));
      dec_rd        = 5'($urandom);
      dec_use_rs1   = 1'($urandom);
      dec_use_rs2   = 1'($urandom);
      dec_use_imm   = 1'($urandom);
      dec_rs1_data  = {$urandom, $urandom};
      dec_rs2_data  = {$urandom, $urandom};
      dec_imm       = {$urandom, $urandom};
      exmem_wen     = 1'($urandom);
      exmem_is_load = 1'($urandom);
      exmem_rd      = 5'($urandom_range(0, 3));
      exmem_data    = {$urandom, $urandom};
      memwb_wen     = 1'($urandom);
      memwb_rd      = 5'($urandom_range(0, 3));
      memwb_data    = {$urandom, $urandom};
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have no parameters; XLEN fixed at 64.
REQ-002 SHALL have ports: clk_i in 1 clock; rst_i in 1 synchronous active-high reset.
REQ-003 SHALL have ports: dec_valid_i in 1; dec_ready_o out 1. Decode handshake.
REQ-004 SHALL have decode payload inputs: dec_op_type_i 4; dec_fu_op_i 7; dec_rs1_i 5; dec_rs2_i 5; dec_use_rs1_i 1; dec_use_rs2_i 1; dec_rs1_data_i 64; dec_rs2_data_i 64; dec_imm_i 64; dec_use_imm_i 1; dec_rd_i 5.
REQ-005 SHALL have EX/MEM forward inputs: exmem_wen_i 1; exmem_is_load_i 1; exmem_rd_i 5; exmem_data_i 64.
REQ-006 SHALL have MEM/WB forward inputs: memwb_wen_i 1; memwb_rd_i 5; memwb_data_i 64.
REQ-007 SHALL have control inputs: ex_stall_i 1 (EX cannot accept); flush_i 1 (kill the issue register).
REQ-008 SHALL have ALU-side outputs: ex_valid_o 1; op_type_o 4; fu_op_o 7; operand_a_o 64; operand_b_o 64; imm_o 64; rd_o 5.
REQ-009 SHALL have output stall_cnt_o 32: count of load-use bubbles.

Function
REQ-010 SHALL hold one registered issue slot; all ALU-side outputs come directly from flops.
REQ-011 Hazard: dec_valid_i & exmem_wen_i & exmem_is_load_i & exmem_rd_i!=0 & ((dec_use_rs1_i & dec_rs1_i==exmem_rd_i) | (dec_use_rs2_i & dec_rs2_i==exmem_rd_i)).
REQ-012 dec_ready_o SHALL be combinational: !ex_stall_i & !hazard & !flush_i.
REQ-013 Accept = dec_valid_i & dec_ready_o; on accept, slot SHALL load the payload next edge with ex_valid_o=1.
REQ-014 When ex_stall_i=1 and flush_i=0, slot SHALL hold all outputs unchanged.
REQ-015 When !ex_stall_i & hazard, slot SHALL load a bubble (ex_valid_o=0) and stall_cnt_o SHALL increment by 1, saturating at 0xFFFF_FFFF.
REQ-016 When !ex_stall_i & !dec_valid_i, slot SHALL load a bubble.
REQ-017 flush_i SHALL take priority over stall and accept: next edge ex_valid_o=0 and no decode transfer.
REQ-018 Forwarding per source operand SHALL be prioritized: EX/MEM (non-load, wen, rd match, rd!=0), then MEM/WB (wen, rd match, rd!=0), then dec_rsX_data_i.
REQ-019 Register x0 SHALL never be forwarded; its operand is dec_rsX_data_i.
REQ-020 operand_a_o SHALL be the forwarded rs1 value.
REQ-021 operand_b_o SHALL be dec_imm_i when dec_use_imm_i=1, else the forwarded rs2 value.
REQ-022 imm_o SHALL always carry dec_imm_i unmodified.
REQ-023 Latency decode-to-ALU SHALL be exactly 1 cycle with no hazard or stall.
REQ-024 After a hazard bubble, the held instruction SHALL issue the next non-stalled cycle, taking the load result via MEM/WB forwarding.
REQ-025 Payload fields with ex_valid_o=0 are don't-care but SHALL NOT be X after reset.

Reset
REQ-026 On rst_i=1 at a clock edge, all of the following SHALL be 0: ex_valid_o, op_type_o, fu_op_o, operand_a_o, operand_b_o, imm_o, rd_o, stall_cnt_o.
REQ-027 dec_ready_o SHALL be 0 while rst_i=1.
REQ-028 Reset SHALL override flush_i and ex_stall_i.
REQ-029 Reset mid-hazard SHALL discard the held instruction; no bubble SHALL be counted.

Verification
REQ-030 Scenario: Plain issue. Stimulus: dec rs1=3 data 0x10, rs2=4 data 0x20, no forwards. Response: next cycle ex_valid_o=1, operand_a_o=0x10, operand_b_o=0x20.
REQ-031 Scenario: Dual match. Stimulus: rs1=5; exmem rd=5 data 0xAA non-load; memwb rd=5 data 0xBB. Response: operand_a_o=0xAA.
REQ-032 Scenario: Load-use. Stimulus: exmem load rd=7; dec rs2=7, use_rs2=1. Response: dec_ready_o=0, one bubble, stall_cnt_o=1. Next cycle, memwb rd=7 data 0x55. Response: operand_b_o=0x55, ex_valid_o=1.
REQ-033 Scenario: x0. Stimulus: rs1=0, exmem rd=0 wen=1 data 0xFF, dec_rs1_data_i=0. Response: operand_a_o=0.
REQ-034 Scenario: Stall then flush. Stimulus: ex_stall_i=1 for 3 cycles. Response: outputs frozen. Stimulus: flush_i with ex_stall_i=1. Response: ex_valid_o=0 next cycle.
REQ-035 Scenario: Immediate. Stimulus: dec_use_imm_i=1, imm=0xFFFF_FFFF_FFFF_FFFC, memwb rd match rs2. Response: operand_b_o=0xFFFF_FFFF_FFFF_FFFC.
